// File: rtl/dmem_vga_pkg.sv
// Shared constants for the data-memory VGA reader: 640x480@60 timing, bitmap geometry, VGA bit layout.
// Optional cursor highlight is enabled with DMEM_VGA_CURSOR_EN.
package dmem_vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_VIS_END  = cnt_t'(H_VISIBLE);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t H_SYNC_END = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_VIS_END  = cnt_t'(V_VISIBLE);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t V_SYNC_END = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  // 64x64 bitmap cells, each cell 4x4 screen pixels, 16 cells per memory word.
  localparam int   SCALE_LOG2 = 2;
  localparam cnt_t BITMAP_END = cnt_t'(256);
  localparam int   WORD_W     = 16;
  localparam int   ADDR_W     = 8;

  localparam int VGA_W        = 7;
  localparam int VGA_HS_BIT   = 6;
  localparam int VGA_VS_BIT   = 5;
  localparam int VGA_COLOR_HI = 4;
  localparam int COLOR_W      = 5;
  localparam logic [VGA_W-1:0] VGA_IDLE = 7'b110_0000;

  // Leftmost cell of a word is its MSB.
  function automatic logic [3:0] bit_of(input logic [3:0] col_lo);
    return 4'd15 - col_lo;
  endfunction

endpackage

// File: rtl/dmem_vga_reader_if.sv
// Bus between the VGA reader (master), data-memory read port B and the VGA pins.
// cursor_addr exists only when DMEM_VGA_CURSOR_EN is defined.
interface dmem_vga_reader_if;
  import dmem_vga_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic [VGA_W-1:0]  vga;
  logic              frame_start;
`ifdef DMEM_VGA_CURSOR_EN
  logic [ADDR_W-1:0] cursor_addr;
`endif

  modport master (
    output mem_addr, vga, frame_start,
    input  mem_data
`ifdef DMEM_VGA_CURSOR_EN
    , input cursor_addr
`endif
  );

  modport slave (
    input  mem_addr, vga, frame_start,
    output mem_data
`ifdef DMEM_VGA_CURSOR_EN
    , output cursor_addr
`endif
  );

endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider plus 800x525 h/v scan counters; raw syncs, visible flag, frame-start pulse.
// CLK_DIV must be at least 2 so the divider has a register bit.
module vga_timing
  import dmem_vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output cnt_t h_o,
  output cnt_t v_o,
  output cnt_t h_next_o,
  output cnt_t v_next_o,
  output logic hs_o,
  output logic vs_o,
  output logic visible_o,
  output logic frame_start_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  cnt_t             h_q, v_q, h_d, v_d;
  logic             frame_start_q;

  assign tick_o = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: defaults first, so every path assigns h_d/v_d and no latch is inferred.
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking, so every register here sees the pre-edge values of the others.
      div_q         <= tick_o ? '0 : div_q + 1'b1;
      frame_start_q <= tick_o && (h_q == H_LAST) && (v_q == V_LAST);
      if (tick_o) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign h_next_o      = h_d;
  assign v_next_o      = v_d;
  assign hs_o          = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
  assign vs_o          = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
  assign visible_o     = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/dmem_vga_reader.sv
// Scans data memory through read port B and draws it as a 64x64 (4x scaled) bitmap on 7-bit VGA.
// Defining DMEM_VGA_CURSOR_EN adds cursor_addr and highlights clear bits of that word.
module dmem_vga_reader
  import dmem_vga_pkg::*;
#(
  parameter int                 CLK_DIV      = 4,
  parameter logic [COLOR_W-1:0] FG_COLOR     = 5'b11111,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 5'b00000,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 5'b11000
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_vga_reader_if.master  bus
);

  logic              tick, hs_raw, vs_raw, visible, frame_start;
  cnt_t              h_cnt, v_cnt, h_next, v_next;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [VGA_W-1:0]  vga_q, vga_d;
  logic [COLOR_W-1:0] color;
  logic              in_bitmap, bit_on, cursor_hit;
  logic              unused_next_bits;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_o        (tick),
    .h_o           (h_cnt),
    .v_o           (v_cnt),
    .h_next_o      (h_next),
    .v_next_o      (v_next),
    .hs_o          (hs_raw),
    .vs_o          (vs_raw),
    .visible_o     (visible),
    .frame_start_o (frame_start)
  );

  // Word for the position the counters move to on this tick: {cell row, cell column / 16}.
  assign mem_addr_d       = {v_next[7:SCALE_LOG2], h_next[7:6]};
  assign unused_next_bits = ^{h_next[9:8], h_next[5:0], v_next[9:8], v_next[1:0]};

  // mem_data now holds the word for (h_cnt, v_cnt), fetched when the counters arrived here.
  assign in_bitmap = visible && (h_cnt < BITMAP_END) && (v_cnt < BITMAP_END);
  assign bit_on    = bus.mem_data[bit_of(h_cnt[5:2])];

`ifdef DMEM_VGA_CURSOR_EN
  assign cursor_hit = (mem_addr_q == bus.cursor_addr);
`else
  assign cursor_hit = 1'b0;
`endif

  always_comb begin
    color = '0;
    if (in_bitmap) begin
      color = bit_on ? FG_COLOR : (cursor_hit ? CURSOR_COLOR : BG_COLOR);
    end
    vga_d                  = '0;
    vga_d[VGA_HS_BIT]      = hs_raw;
    vga_d[VGA_VS_BIT]      = vs_raw;
    vga_d[VGA_COLOR_HI:0]  = color;
  end

  // Syncs and colour share one register stage so they stay aligned one pixel behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      vga_q      <= VGA_IDLE;
    end else if (tick) begin
      mem_addr_q <= mem_addr_d;
      vga_q      <= vga_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.vga         = vga_q;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_dmem_vga_reader.sv
// Self-checking bench for dmem_vga_reader: directed vector table plus random-memory scan against a pixel model.
// Build with DMEM_VGA_CURSOR_EN defined to exercise the cursor highlight.
module tb_dmem_vga_reader;

  localparam int DIV       = 4;
  localparam int FRAME_PIX = 800 * 525;

  logic clk = 1'b0;
  logic rst_n;

  dmem_vga_reader_if bus ();

  dmem_vga_reader #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous block RAM behind read port B.
  logic [15:0] mem [256];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

`ifdef DMEM_VGA_CURSOR_EN
  logic [7:0] cur_addr;
  assign bus.cursor_addr = cur_addr;
`endif

  // Rising edges since reset release; edge 4n moves the scan to pixel n.
  int unsigned edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  int n_vec = 0;
  int n_bad = 0;
  int unsigned hs_low_cnt, hs_first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // ---------------- reference model: scan order pixel p -> what the screen should show -------------
  function automatic logic [6:0] pix_vga(input int unsigned p);
    int unsigned h, v, word_idx, bit_idx;
    logic hs, vs;
    logic [4:0] col;
    logic [15:0] w;
    h   = p % 800;
    v   = (p / 800) % 525;
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= 490 && v < 492);
    col = 5'b00000;
    if (h < 256 && v < 256) begin
      word_idx = (v / 4) * 4 + h / 64;
      bit_idx  = 15 - (h / 4) % 16;
      w        = mem[word_idx];
      if (w[bit_idx]) col = 5'b11111;
`ifdef DMEM_VGA_CURSOR_EN
      else if (word_idx == int'(cur_addr)) col = 5'b11000;
`endif
      else col = 5'b00000;
    end
    return {hs, vs, col};
  endfunction

  function automatic bit pix_in_bitmap(input int unsigned p);
    return ((p % 800) < 256) && (((p / 800) % 525) < 256);
  endfunction

  function automatic logic [7:0] pix_addr(input int unsigned p);
    return 8'(((p / 800) % 525 / 4) * 4 + (p % 800) / 64);
  endfunction

  // Output registers lag the counters by one pixel; before the first tick they hold reset values.
  function automatic logic [6:0] exp_vga_at(input int unsigned k);
    return (k < DIV) ? 7'h60 : pix_vga(k / DIV - 1);
  endfunction

  function automatic logic exp_fs_at(input int unsigned k);
    return (k >= DIV) && (k % DIV == 0) && ((k / DIV) % FRAME_PIX == 0);
  endfunction

  task automatic wait_edge(input int unsigned k);
    while (edges < k) @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int unsigned ncyc, input string tag);
    int unsigned p;
    int bad0;
    bad0       = n_bad;
    hs_low_cnt = 0;
    hs_first   = 0;
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(negedge clk);
      p = edges / DIV;
      check({tag, "_vga"}, 32'(bus.vga), 32'(exp_vga_at(edges)));
      check({tag, "_fs"}, 32'(bus.frame_start), 32'(exp_fs_at(edges)));
      if (pix_in_bitmap(p)) check({tag, "_addr"}, 32'(bus.mem_addr), 32'(pix_addr(p)));
      if (!bus.vga[6]) begin
        if (hs_low_cnt == 0) hs_first = edges;
        hs_low_cnt++;
      end
      if (n_bad - bad0 > 16) break;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int unsigned h;
    int unsigned v;
    logic        chk_addr;
    logic [7:0]  exp_addr;
    logic [6:0]  exp_vga;
    string       name;
  } vec_t;

`ifdef DMEM_VGA_CURSOR_EN
  localparam logic [6:0] EXP_4_0 = 7'h78;
`else
  localparam logic [6:0] EXP_4_0 = 7'h60;
`endif

  vec_t tbl [16];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned p;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
`ifdef DMEM_VGA_CURSOR_EN
    cur_addr = 8'h00;
`endif

    // Reset state, asynchronously applied before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_vga", 32'(bus.vga), 32'h60);
    check("rst_addr", 32'(bus.mem_addr), 32'h00);
    check("rst_fs", 32'(bus.frame_start), 32'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_vga", 32'(bus.vga), 32'h60);

    // Reset mid-line while HS is low: outputs must drop to reset values without a clock edge.
    release_reset();
    wait_edge(DIV * (700 + 1));
    check("pre_rst_vga", 32'(bus.vga), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vga", 32'(bus.vga), 32'h60);
    check("async_rst_addr", 32'(bus.mem_addr), 32'h00);
    check("async_rst_fs", 32'(bus.frame_start), 32'h0);
    release_reset();
    scan(DIV * 40, "restart");

    // Directed mapping / address / blanking vectors.
    hold_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h8000;
    mem[5] = 16'h8000;
    mem[7] = 16'h0001;
    tbl[0]  = '{0,   0, 1'b1, 8'h00, 7'h7F,   "px_0_0"};
    tbl[1]  = '{3,   0, 1'b1, 8'h00, 7'h7F,   "px_3_0"};
    tbl[2]  = '{4,   0, 1'b1, 8'h00, EXP_4_0, "px_4_0"};
    tbl[3]  = '{64,  0, 1'b1, 8'h01, 7'h60,   "px_64_0"};
    tbl[4]  = '{255, 0, 1'b1, 8'h03, 7'h60,   "px_255_0"};
    tbl[5]  = '{256, 0, 1'b0, 8'h00, 7'h60,   "px_256_0"};
    tbl[6]  = '{640, 0, 1'b0, 8'h00, 7'h60,   "px_640_0"};
    tbl[7]  = '{700, 0, 1'b0, 8'h00, 7'h20,   "px_700_0"};
    tbl[8]  = '{0,   3, 1'b1, 8'h00, 7'h7F,   "px_0_3"};
    tbl[9]  = '{3,   3, 1'b1, 8'h00, 7'h7F,   "px_3_3"};
    tbl[10] = '{0,   4, 1'b1, 8'h04, 7'h60,   "px_0_4"};
    tbl[11] = '{64,  4, 1'b1, 8'h05, 7'h7F,   "px_64_4"};
    tbl[12] = '{67,  7, 1'b1, 8'h05, 7'h7F,   "px_67_7"};
    tbl[13] = '{68,  7, 1'b1, 8'h05, 7'h60,   "px_68_7"};
    tbl[14] = '{251, 7, 1'b1, 8'h07, 7'h60,   "px_251_7"};
    tbl[15] = '{255, 7, 1'b1, 8'h07, 7'h7F,   "px_255_7"};
    release_reset();
    for (int i = 0; i < 16; i++) begin
      p = tbl[i].v * 800 + tbl[i].h;
      wait_edge(DIV * p);
      if (tbl[i].chk_addr) check({tbl[i].name, "_addr"}, 32'(bus.mem_addr), 32'(tbl[i].exp_addr));
      wait_edge(DIV * (p + 1));
      check({tbl[i].name, "_vga"}, 32'(bus.vga), 32'(tbl[i].exp_vga));
    end

    // All bits set: foreground only inside x<256, plus HS timing over two lines.
    hold_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    release_reset();
    scan(DIV * 800 * 2, "blank");
    check("hs_first_low_edge", hs_first, DIV * (656 + 1));
    check("hs_low_cycles", hs_low_cnt, 2 * 96 * DIV);

    // Random memory contents against the pixel model.
    hold_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
`ifdef DMEM_VGA_CURSOR_EN
    cur_addr = 8'($urandom_range(0, 7));
`endif
    release_reset();
    scan(DIV * 800 * 5, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
